seg_scan: RTL

Time-multiplexed seven-segment display driver for the board's 8-digit hex display. It runs on `clk_board` and uses the divided `clk_led` square wave from the clock divider as its scan-rate source. It advances one digit per rising edge of `clk_led`, decodes a frame-latched 32-bit value into hex glyphs, and inserts a guard blank between digits to suppress ghosting.

---
 rtl/seg_scan_if.sv | 55 +++++
 rtl/seg_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_if
//  Description : Signal bundle between a display-value source and the
//                seg_scan seven-segment scanner.
//                master : drives the scan-rate wave, the value, the decimal
//                         points and the enable; observes the display pins.
//                slave  : the scanner itself.
//  Signals     : clk_led    scan-rate square wave (clk_board domain)
//                value      32-bit hex value, nibble k -> digit k
//                dp         per-digit decimal point, 1 = lit
//                enable     0 forces every anode inactive
//                an         one-hot digit select (polarity per AN_ACTIVE_LOW)
//                seg        segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//                seg_dp     decimal-point segment
//                frame_done one-cycle pulse when a new frame is latched
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_if #(
   parameter int DIGITS = 8
) ();

   logic              clk_led;
   logic [31:0]       value;
   logic [DIGITS-1:0] dp;
   logic              enable;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;
   logic              seg_dp;
   logic              frame_done;

   modport master (
      output clk_led,
      output value,
      output dp,
      output enable,
      input  an,
      input  seg,
      input  seg_dp,
      input  frame_done
   );

   modport slave (
      input  clk_led,
      input  value,
      input  dp,
      input  enable,
      output an,
      output seg,
      output seg_dp,
      output frame_done
   );

endinterface
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan
//  Description : Time-multiplexed driver for a multi-digit hex seven-segment
//                display. One digit is advanced per rising edge of the
//                clk_led scan wave. The displayed 32-bit value and decimal
//                points are latched once per frame (on the wrap from the last
//                digit back to digit 0) so a frame is always shown
//                atomically. After every digit change the anodes are held off
//                for GUARD clk_board cycles to suppress ghosting. Optional
//                leading-zero blanking hides upper zero digits (digit 0 is
//                always shown).
//  Ports       : clk_board  in   board clock, the only clock of the block
//                rst_n      in   asynchronous active-low reset
//                bus        slave modport of seg_scan_if (scan wave, value,
//                           decimal points, enable in; an/seg/seg_dp and
//                           frame_done out, all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan #(
   parameter int DIGITS         = 8,   // digits scanned, 1..8
   parameter int GUARD          = 16,  // anode-off cycles after a change, 0..255
   parameter int SEG_ACTIVE_LOW = 1,   // 1: seg/seg_dp low = lit
   parameter int AN_ACTIVE_LOW  = 1,   // 1: an low = selected
   parameter int BLANK_LEADING  = 1    // 1: blank leading zero digits
) (
   input  wire logic   clk_board,
   input  wire logic   rst_n,
   seg_scan_if.slave   bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0]     c_last_idx = IW'(DIGITS - 1);
   localparam logic [7:0]        c_guard    = 8'(GUARD);
   localparam logic [DIGITS-1:0] c_an_idle  = (AN_ACTIVE_LOW  != 0) ? '1 : '0;
   localparam logic [6:0]        c_seg_idle = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic              c_dp_idle  = (SEG_ACTIVE_LOW != 0);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic              clk_led_q;
   logic [IW-1:0]     idx_q,        idx_d;
   logic [7:0]        gcnt_q,       gcnt_d;
   logic [31:0]       value_l_q,    value_l_d;
   logic [DIGITS-1:0] dp_l_q,       dp_l_d;
   logic              frame_done_q, frame_done_d;
   logic [DIGITS-1:0] an_q,         an_d;
   logic [6:0]        seg_q,        seg_d;
   logic              seg_dp_q,     seg_dp_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic              w_scan_tick;
   logic              w_last;
   logic [DIGITS-1:0] w_nz;          // per-digit "latched nibble is nonzero"
   logic [3:0]        w_nibble;
   logic              w_dp_sel;
   logic [DIGITS-1:0] w_onehot;
   logic [6:0]        w_glyph;
   logic              w_upper_zero;
   logic              w_blanked;
   logic              w_vis;

   // clk_led is already a clk_board-domain register output, so a single
   // delay stage is enough for a clean rising-edge detect.
   assign w_scan_tick = bus.clk_led & ~clk_led_q;
   assign w_last      = (idx_q == c_last_idx);

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_nz
         assign w_nz[k] = |value_l_q[4*k +: 4];
      end
   endgenerate

   // Select the current digit's nibble, decimal point and anode bit.
   always_comb begin
      w_nibble = 4'h0;
      w_dp_sel = 1'b0;
      w_onehot = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            w_nibble    = value_l_q[4*k +: 4];
            w_dp_sel    = dp_l_q[k];
            w_onehot[k] = 1'b1;
         end
      end
   end

   // Active-high hex glyph, segments ordered {g,f,e,d,c,b,a}.
   always_comb begin
      w_glyph = 7'h00;
      case (w_nibble)
         4'h0: w_glyph = 7'h3F;
         4'h1: w_glyph = 7'h06;
         4'h2: w_glyph = 7'h5B;
         4'h3: w_glyph = 7'h4F;
         4'h4: w_glyph = 7'h66;
         4'h5: w_glyph = 7'h6D;
         4'h6: w_glyph = 7'h7D;
         4'h7: w_glyph = 7'h07;
         4'h8: w_glyph = 7'h7F;
         4'h9: w_glyph = 7'h6F;
         4'hA: w_glyph = 7'h77;
         4'hB: w_glyph = 7'h7C;
         4'hC: w_glyph = 7'h39;
         4'hD: w_glyph = 7'h5E;
         4'hE: w_glyph = 7'h79;
         4'hF: w_glyph = 7'h71;
         default: w_glyph = 7'h00;
      endcase
   end

   // A digit is a leading zero when it and every digit above it are zero.
   // Shifting the nonzero mask down by idx leaves exactly those digits.
   assign w_upper_zero = ((w_nz >> idx_q) == '0);
   assign w_blanked    = (BLANK_LEADING != 0) && (idx_q != '0) && w_upper_zero;
   assign w_vis        = bus.enable & (gcnt_q == 8'd0) & ~w_blanked;

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      idx_d        = idx_q;
      gcnt_d       = gcnt_q;
      value_l_d    = value_l_q;
      dp_l_d       = dp_l_q;
      frame_done_d = 1'b0;

      if (w_scan_tick) begin
         // Guard restarts on every digit change; the outputs below are built
         // from the current (old) state, so the previous digit stays on one
         // more cycle before the guard blanks it.
         gcnt_d = c_guard;
         if (w_last) begin
            idx_d        = '0;
            value_l_d    = bus.value;
            dp_l_d       = bus.dp;
            frame_done_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (gcnt_q != 8'd0) begin
         gcnt_d = gcnt_q - 8'd1;
      end
   end

   // Registered display pins, polarity applied last.
   always_comb begin
      an_d     = w_vis ? w_onehot : '0;
      seg_d    = w_vis ? w_glyph  : 7'h00;
      seg_dp_d = w_vis & w_dp_sel;
      if (AN_ACTIVE_LOW != 0) begin
         an_d = ~an_d;
      end
      if (SEG_ACTIVE_LOW != 0) begin
         seg_d    = ~seg_d;
         seg_dp_d = ~seg_dp_d;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         clk_led_q    <= 1'b0;
         idx_q        <= '0;
         gcnt_q       <= c_guard;
         value_l_q    <= 32'h0;
         dp_l_q       <= '0;
         frame_done_q <= 1'b0;
         an_q         <= c_an_idle;
         seg_q        <= c_seg_idle;
         seg_dp_q     <= c_dp_idle;
      end else begin
         clk_led_q    <= bus.clk_led;
         idx_q        <= idx_d;
         gcnt_q       <= gcnt_d;
         value_l_q    <= value_l_d;
         dp_l_q       <= dp_l_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         seg_dp_q     <= seg_dp_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.seg_dp     = seg_dp_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
